// File: rtl/restaurant_order.sv
// Single-order lifecycle controller: IDLE -> ORDERED -> COOKING -> READY -> IDLE.
// Moore FSM; state_out is the raw state register, so it has no input-to-output path.
module restaurant_order (
    input  logic       clk,
    input  logic       reset,
    input  logic       place_order,
    input  logic       start_cooking,
    input  logic       food_ready,
    input  logic       serve_done,
    output logic [1:0] state_out
);

    typedef enum logic [1:0] {
        IDLE    = 2'd0,
        ORDERED = 2'd1,
        COOKING = 2'd2,
        READY   = 2'd3
    } state_t;

    state_t state_p0;
    state_t state_nxt;

    // Stage 0: state register, reset has priority over every event
    always_ff @(posedge clk) begin
        if (reset) begin
            state_p0 <= IDLE;
        end else begin
            state_p0 <= state_nxt;
        end
    end

    // Each state examines only its own advancing event; one step per edge
    always_comb begin
        state_nxt = state_p0;
        unique case (state_p0)
            IDLE:    if (place_order)   state_nxt = ORDERED;
            ORDERED: if (start_cooking) state_nxt = COOKING;
            COOKING: if (food_ready)    state_nxt = READY;
            READY:   if (serve_done)    state_nxt = IDLE;
            default: state_nxt = IDLE;
        endcase
    end

    assign state_out = state_p0;

endmodule

// File: tb/tb_restaurant_order.sv
// Directed bench for restaurant_order: table of per-edge input vectors with
// hand-computed state codes, followed by reset-from-every-state sequences.
module tb_restaurant_order;

    logic       clk = 1'b0;
    logic       reset;
    logic       place_order;
    logic       start_cooking;
    logic       food_ready;
    logic       serve_done;
    logic [1:0] state_out;

    int n_cmp = 0;
    int n_bad = 0;

    restaurant_order dut (
        .clk           (clk),
        .reset         (reset),
        .place_order   (place_order),
        .start_cooking (start_cooking),
        .food_ready    (food_ready),
        .serve_done    (serve_done),
        .state_out     (state_out)
    );

    always #5 clk = ~clk;

    typedef struct packed {
        logic       rst;
        logic       po;
        logic       sc;
        logic       fr;
        logic       sd;
        logic [1:0] exp;
    } vec_t;

    vec_t vecs[$];

    function automatic void add(input logic r, input logic p, input logic s,
                                input logic f, input logic d, input logic [1:0] e);
        vec_t v;
        v.rst = r; v.po = p; v.sc = s; v.fr = f; v.sd = d; v.exp = e;
        vecs.push_back(v);
    endfunction

    // Drive one edge's inputs, clock it, sample 1 time unit after the edge.
    task automatic step(input logic r, input logic p, input logic s,
                        input logic f, input logic d);
        reset = r; place_order = p; start_cooking = s; food_ready = f; serve_done = d;
        @(posedge clk);
        #1;
    endtask

    task automatic check(input string name, input logic [1:0] exp);
        n_cmp++;
        if (state_out !== exp) begin
            n_bad++;
            $display("FAIL %s: state_out=%b expected=%b", name, state_out, exp);
        end
    endtask

    initial begin
        reset = 1'b0; place_order = 1'b0; start_cooking = 1'b0;
        food_ready = 1'b0; serve_done = 1'b0;

        // reset, then idle hold
        add(1,0,0,0,0, 2'd0);
        add(0,0,0,0,0, 2'd0);
        add(0,0,0,0,0, 2'd0);
        // happy path
        add(0,1,0,0,0, 2'd1);
        add(0,0,1,0,0, 2'd2);
        add(0,0,0,1,0, 2'd3);
        add(0,0,0,0,1, 2'd0);
        // out-of-order events in IDLE and ORDERED are ignored
        add(0,0,0,1,0, 2'd0);
        add(0,0,1,0,0, 2'd0);
        add(0,0,0,0,1, 2'd0);
        add(0,1,0,0,0, 2'd1);
        add(0,0,0,1,0, 2'd1);
        add(0,0,0,0,1, 2'd1);
        add(0,1,0,0,0, 2'd1);
        // back to IDLE, then all inputs high for 5 edges
        add(1,0,0,0,0, 2'd0);
        add(0,1,1,1,1, 2'd1);
        add(0,1,1,1,1, 2'd2);
        add(0,1,1,1,1, 2'd3);
        add(0,1,1,1,1, 2'd0);
        add(0,1,1,1,1, 2'd1);
        // reach COOKING, then reset wins over food_ready
        add(0,0,1,0,0, 2'd2);
        add(1,0,0,1,0, 2'd0);
        // COOKING hold for 4 edges, then food_ready; READY holds without serve_done
        add(0,1,0,0,0, 2'd1);
        add(0,0,1,0,0, 2'd2);
        add(0,0,0,0,0, 2'd2);
        add(0,1,1,0,1, 2'd2);
        add(0,0,0,0,0, 2'd2);
        add(0,0,0,0,0, 2'd2);
        add(0,0,0,1,0, 2'd3);
        add(0,1,1,1,0, 2'd3);
        // reset in READY with serve_done asserted
        add(1,0,0,0,1, 2'd0);

        foreach (vecs[i]) begin
            step(vecs[i].rst, vecs[i].po, vecs[i].sc, vecs[i].fr, vecs[i].sd);
            check($sformatf("vec%0d", i), vecs[i].exp);
        end

        // reset from every state, with all event inputs high on the reset edge
        for (int s = 0; s < 4; s++) begin
            step(1,0,0,0,0);
            check($sformatf("pre_reset_s%0d", s), 2'd0);
            if (s >= 1) step(0,1,0,0,0);
            if (s >= 2) step(0,0,1,0,0);
            if (s >= 3) step(0,0,0,1,0);
            check($sformatf("reach_s%0d", s), 2'(s));
            step(1,1,1,1,1);
            check($sformatf("reset_from_s%0d", s), 2'd0);
        end

        // wrap-around: served order returns to IDLE, next order accepted next edge
        step(0,1,0,0,0);
        step(0,0,1,0,0);
        step(0,0,0,1,0);
        step(0,0,0,0,1);
        check("wrap_idle", 2'd0);
        step(0,1,0,0,0);
        check("wrap_new_order", 2'd1);

        $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_bad);
        $finish;
    end

endmodule
